// File: rtl/timer_run_controller.sv
// Run/pause/done sequencer for the countdown timer's cascaded BCD down-counter chain.
// Decodes debounced keys and the door interlock, prescales the count tick, registers all outputs.
module timer_run_controller #(
    parameter int unsigned TICK_DIV    = 4,
    parameter int unsigned DONE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       key_loadn,
    input  logic       key_startn,
    input  logic       key_stopn,
    input  logic       key_clrn,
    input  logic       door_closed,
    input  logic       zero,
    output logic       cnt_loadn,
    output logic       cnt_clearn,
    output logic       cnt_en,
    output logic       heat_on,
    output logic       done,
    output logic [2:0] state_o
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DONE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DONE_TOP  = DW'(DONE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLR   = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state, next;
    logic [PW-1:0] presc, presc_next;
    logic [DW-1:0] dcnt, dcnt_next;
    logic [3:0]    key_cur, key_prev, edges;
    logic          clr_e, stop_e, start_e, load_e, tick;

    // Key bit order: {clear, stop, start, load}; an edge is previous 1, current 0.
    assign edges   = key_prev & ~key_cur;
    assign clr_e   = edges[3];
    assign stop_e  = edges[2];
    assign start_e = edges[1];
    assign load_e  = edges[0];
    assign state_o = state;

    always_comb begin
        next       = state;
        presc_next = presc;
        dcnt_next  = '0;
        case (state)
            S_IDLE: begin
                if (clr_e)
                    next = S_CLR;
                else if (stop_e)
                    next = S_IDLE;
                else if (start_e) begin
                    if (door_closed && !zero)
                        next = S_RUN;
                end else if (load_e)
                    next = S_LOAD;
            end
            S_LOAD:  next = S_IDLE;
            S_CLR: begin
                next       = S_IDLE;
                presc_next = '0;
            end
            S_RUN: begin
                if (clr_e)
                    next = S_CLR;
                else if (stop_e || !door_closed)
                    next = S_PAUSE;
                else if (zero)
                    next = S_DONE;
                else
                    presc_next = (presc == PRESC_TOP) ? '0 : presc + PW'(1);
            end
            S_PAUSE: begin
                if (clr_e)
                    next = S_CLR;
                else if (stop_e)
                    next = S_PAUSE;
                else if (start_e && door_closed)
                    next = S_RUN;
            end
            S_DONE: begin
                if (clr_e)
                    next = S_CLR;
                else if (dcnt == DONE_TOP)
                    next = S_IDLE;
                else
                    dcnt_next = dcnt + DW'(1);
            end
            default: next = S_IDLE;
        endcase
    end

    // Tick follows the prescaler value of the upcoming cycle, so it lines up with TICK_DIV-1.
    assign tick = (next == S_RUN) && (presc_next == PRESC_TOP) && !zero;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state      <= S_IDLE;
            presc      <= '0;
            dcnt       <= '0;
            key_cur    <= '1;
            key_prev   <= '1;
            cnt_loadn  <= 1'b1;
            cnt_clearn <= 1'b1;
            cnt_en     <= 1'b0;
            heat_on    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= next;
            presc      <= presc_next;
            dcnt       <= dcnt_next;
            key_cur    <= {key_clrn, key_stopn, key_startn, key_loadn};
            key_prev   <= key_cur;
            cnt_loadn  <= (next != S_LOAD);
            cnt_clearn <= (next != S_CLR);
            cnt_en     <= tick;
            heat_on    <= (next == S_RUN);
            done       <= (next == S_DONE);
        end
    end

endmodule

// File: tb/tb_timer_run_controller.sv
// Directed bench for timer_run_controller with a tiny datapath model driving zero.
module tb_timer_run_controller;

    logic       clk = 1'b0;
    logic       clearn;
    logic       key_loadn, key_startn, key_stopn, key_clrn;
    logic       door_closed, zero;
    logic       cnt_loadn, cnt_clearn, cnt_en, heat_on, done;
    logic [2:0] state_o;
    logic [7:0] obs;
    logic [3:0] dp = 4'd0;
    logic [3:0] preset = 4'd2;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    // Expected {state_o, cnt_loadn, cnt_clearn, cnt_en, heat_on, done}
    localparam logic [7:0] IDLE_O  = 8'b000_11000;
    localparam logic [7:0] LOAD_O  = 8'b001_01000;
    localparam logic [7:0] CLR_O   = 8'b010_10000;
    localparam logic [7:0] RUN_O   = 8'b011_11010;
    localparam logic [7:0] TICK_O  = 8'b011_11110;
    localparam logic [7:0] PAUSE_O = 8'b100_11000;
    localparam logic [7:0] DONE_O  = 8'b101_11001;

    timer_run_controller #(.TICK_DIV(4), .DONE_CYCLES(3)) dut (
        .clk(clk), .clearn(clearn),
        .key_loadn(key_loadn), .key_startn(key_startn),
        .key_stopn(key_stopn), .key_clrn(key_clrn),
        .door_closed(door_closed), .zero(zero),
        .cnt_loadn(cnt_loadn), .cnt_clearn(cnt_clearn), .cnt_en(cnt_en),
        .heat_on(heat_on), .done(done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs  = {state_o, cnt_loadn, cnt_clearn, cnt_en, heat_on, done};
    assign zero = (dp == 4'd0);

    always @(posedge clk) begin
        if (!cnt_loadn)
            dp <= preset;
        else if (!cnt_clearn)
            dp <= 4'd0;
        else if (cnt_en && dp != 4'd0)
            dp <= dp - 4'd1;
    end

    task automatic pop_cmp();
        logic [7:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", t, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        pop_cmp();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_now(input string tag, input logic [7:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        pop_cmp();
    endtask

    task automatic do_load(input logic [3:0] v);
        preset    = v;
        key_loadn = 1'b0;
        chk("load_pre", IDLE_O);
        chk("load_detect", IDLE_O);
        chk("load_pulse", LOAD_O);
        chk("load_back", IDLE_O);
        key_loadn = 1'b1;
        chk("load_release", IDLE_O);
    endtask

    // Caller has just driven key_startn low; datapath holds 00:02.
    task automatic full_run(input string tag, input bit load_mid);
        chk({tag, "_pre"}, IDLE_O);
        chk({tag, "_detect"}, IDLE_O);
        for (int i = 0; i < 8; i++) begin
            if (load_mid && i == 1)
                key_loadn = 1'b0;
            chk({tag, "_run"}, (i == 3 || i == 7) ? TICK_O : RUN_O);
        end
        chk({tag, "_zero"}, RUN_O);
        for (int i = 0; i < 3; i++)
            chk({tag, "_done"}, DONE_O);
        chk({tag, "_idle"}, IDLE_O);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        clearn      = 1'b0;
        {key_loadn, key_startn, key_stopn, key_clrn} = 4'hF;
        door_closed = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 2; i++) begin
            {key_loadn, key_startn, key_stopn, key_clrn} = 4'($urandom);
            chk("reset", IDLE_O);
        end
        {key_loadn, key_startn, key_stopn, key_clrn} = 4'hF;
        clearn = 1'b1;
        chk("after_reset", IDLE_O);

        // Load then run to expiry; start stays held past DONE
        do_load(4'd2);
        key_startn = 1'b0;
        full_run("run", 1'b0);
        chk("start_held", IDLE_O);
        chk("start_held", IDLE_O);
        key_startn = 1'b1;

        // Pause by stop, resume, then pause by door
        do_load(4'd5);
        key_startn = 1'b0;
        chk("p_pre", IDLE_O);
        chk("p_detect", IDLE_O);
        key_startn = 1'b1;
        chk("p_run", RUN_O);
        chk("p_run", RUN_O);
        chk("p_run", RUN_O);
        chk("p_tick1", TICK_O);
        key_stopn = 1'b0;
        chk("p_run", RUN_O);
        chk("p_stop_detect", RUN_O);
        chk("p_paused", PAUSE_O);
        key_stopn = 1'b1;
        chk("p_paused", PAUSE_O);
        chk("p_paused", PAUSE_O);
        key_startn = 1'b0;
        chk("p_resume_pre", PAUSE_O);
        chk("p_resume_detect", PAUSE_O);
        key_startn = 1'b1;
        chk("p_resumed", RUN_O);
        chk("p_resumed", RUN_O);
        chk("p_tick2", TICK_O);
        door_closed = 1'b0;
        chk("door_open", RUN_O);
        chk("door_paused", PAUSE_O);
        chk("door_paused", PAUSE_O);

        // Clear and start together from PAUSE: clear wins
        door_closed = 1'b1;
        key_clrn    = 1'b0;
        key_startn  = 1'b0;
        chk("prio_pre", PAUSE_O);
        chk("prio_detect", PAUSE_O);
        chk("prio_clr", CLR_O);
        chk("prio_idle", IDLE_O);
        chk("prio_idle", IDLE_O);
        key_clrn   = 1'b1;
        key_startn = 1'b1;

        // Guards: start with zero=1, then start with door open
        key_startn = 1'b0;
        for (int i = 0; i < 4; i++)
            chk("guard_zero", IDLE_O);
        key_startn = 1'b1;
        chk("guard_zero", IDLE_O);
        do_load(4'd2);
        door_closed = 1'b0;
        key_startn  = 1'b0;
        for (int i = 0; i < 4; i++)
            chk("guard_door", IDLE_O);
        key_startn  = 1'b1;
        door_closed = 1'b1;
        chk("guard_door", IDLE_O);

        // Load key pressed during RUN is ignored
        key_startn = 1'b0;
        full_run("runload", 1'b1);
        key_startn = 1'b1;
        key_loadn  = 1'b1;
        chk("runload_after", IDLE_O);

        // Asynchronous reset in the middle of a tick cycle
        do_load(4'd2);
        key_startn = 1'b0;
        chk("ar_pre", IDLE_O);
        chk("ar_detect", IDLE_O);
        key_startn = 1'b1;
        chk("ar_run", RUN_O);
        chk("ar_run", RUN_O);
        chk("ar_run", RUN_O);
        #1;
        chk_now("ar_tick", TICK_O);
        #1;
        clearn = 1'b0;
        #1;
        chk_now("ar_async", IDLE_O);
        #1;
        clearn = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_after", IDLE_O);
        chk("ar_after", IDLE_O);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
